// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared bus-cycle state, transfer record and constants
package bus_pkg;

    typedef enum logic [5:0] {
        IDLE = 6'b000001,
        T1   = 6'b000010,
        T2   = 6'b000100,
        T3   = 6'b001000,
        TW   = 6'b010000,
        T4   = 6'b100000
    } bus_state_t;

    typedef struct packed {
        logic [19:0] addr;
        logic [7:0]  wdata;
        logic        wr;
        logic        iom;
        logic        id;
    } xfer_t;

    localparam logic [7:0] TIMEOUT_DATA = 8'hFF;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant with registered priority pointer
module rr_arbiter2 (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] req,
    input  logic       update,
    output logic       gid,
    output logic       any
);

    logic ptr;

    always_comb begin
        any = |req;
        gid = req[ptr] ? ptr : ~ptr;
    end

    // Once a grant is taken, priority passes to the other requester
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ptr <= 1'b0;
        end else if (update && any) begin
            ptr <= ~gid;
        end
    end

endmodule

// File: rtl/bus_cycle_arbiter.sv
// rtl/bus_cycle_arbiter.sv - two-requester arbiter driving 8086-style T1..T4 bus cycles
module bus_cycle_arbiter
    import bus_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int MAX_WAIT = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       req_wr,
    input  logic [NREQ-1:0]       req_iom,
    input  logic [NREQ-1:0][19:0] req_addr,
    input  logic [NREQ-1:0][7:0]  req_wdata,
    output logic [NREQ-1:0]       ack,
    output logic                  err,
    output logic [7:0]            rdata,
    output logic                  ALE,
    output logic                  RD,
    output logic                  WR,
    output logic                  IOM,
    output logic [19:0]           Address,
    output logic [7:0]            Data_out,
    output logic                  DEN,
    input  logic [7:0]            Data_in,
    input  logic                  READY
);

    bus_state_t state_q, state_d;
    xfer_t      xfer_q;
    logic [3:0] wait_cnt;
    logic       timeout_q;

    logic [1:0] arb_req;
    logic [1:0] done_mask;
    logic       arb_point;
    logic       arb_gid;
    logic       arb_any;
    logic       strobe;

    // The requester acknowledged in T4 is masked so a held req cannot win back-to-back
    always_comb begin
        done_mask = '0;
        if (state_q == T4) begin
            done_mask[xfer_q.id] = 1'b1;
        end
        arb_req   = req & ~done_mask;
        arb_point = (state_q == IDLE) || (state_q == T4);
    end

    rr_arbiter2 u_arb (
        .CLK    (CLK),
        .RESET  (RESET),
        .req    (arb_req),
        .update (arb_point),
        .gid    (arb_gid),
        .any    (arb_any)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_any) state_d = T1;
            T1:      state_d = T2;
            T2:      state_d = T3;
            T3:      state_d = READY ? T4 : TW;
            TW:      if (READY || (wait_cnt == 4'(MAX_WAIT))) state_d = T4;
            T4:      state_d = arb_any ? T1 : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            xfer_q    <= '0;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
            rdata     <= '0;
            Data_out  <= '0;
        end else begin
            state_q <= state_d;
            if (arb_point && arb_any) begin
                xfer_q.addr  <= req_addr[arb_gid];
                xfer_q.wdata <= req_wdata[arb_gid];
                xfer_q.wr    <= req_wr[arb_gid];
                xfer_q.iom   <= req_iom[arb_gid];
                xfer_q.id    <= arb_gid;
            end
            if ((state_q == T1) && xfer_q.wr) begin
                Data_out <= xfer_q.wdata;
            end
            case (state_q)
                T3: begin
                    if (READY) begin
                        if (!xfer_q.wr) rdata <= Data_in;
                    end else begin
                        wait_cnt <= 4'd1;
                    end
                end
                TW: begin
                    if (READY) begin
                        if (!xfer_q.wr) rdata <= Data_in;
                    end else if (wait_cnt == 4'(MAX_WAIT)) begin
                        timeout_q <= 1'b1;
                        rdata     <= TIMEOUT_DATA;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                T4: begin
                    timeout_q <= 1'b0;
                    wait_cnt  <= '0;
                end
                default: ;
            endcase
        end
    end

    // Pins decode from state; address/IOM/data hold in their registers between cycles
    always_comb begin
        strobe  = (state_q == T2) || (state_q == T3) || (state_q == TW);
        ALE     = (state_q == T1);
        RD      = ~(strobe && !xfer_q.wr);
        WR      = ~(strobe && xfer_q.wr);
        DEN     = xfer_q.wr && (strobe || (state_q == T4));
        IOM     = xfer_q.iom;
        Address = xfer_q.addr;
        ack     = '0;
        if (state_q == T4) begin
            ack[xfer_q.id] = 1'b1;
        end
        err = (state_q == T4) && timeout_q;
    end

endmodule

// File: tb/tb_bus_cycle_arbiter.sv
// tb/tb_bus_cycle_arbiter.sv - directed table, corner sequences and random traffic against a transaction model
module tb_bus_cycle_arbiter;

    localparam int MW = 8;

    logic             CLK = 1'b0;
    logic             RESET;
    logic [1:0]       req, req_wr, req_iom;
    logic [1:0][19:0] req_addr;
    logic [1:0][7:0]  req_wdata;
    logic [1:0]       ack;
    logic             err;
    logic [7:0]       rdata;
    logic             ALE, RD, WR, IOM, DEN;
    logic [19:0]      Address;
    logic [7:0]       Data_out;
    logic [7:0]       Data_in = 8'h00;
    logic             READY = 1'b0;

    bus_cycle_arbiter #(.NREQ(2), .MAX_WAIT(MW)) dut (
        .CLK(CLK), .RESET(RESET), .req(req), .req_wr(req_wr), .req_iom(req_iom),
        .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack), .err(err), .rdata(rdata),
        .ALE(ALE), .RD(RD), .WR(WR), .IOM(IOM), .Address(Address), .Data_out(Data_out),
        .DEN(DEN), .Data_in(Data_in), .READY(READY)
    );

    always #5 CLK = ~CLK;

    int passes = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h required %0h", name, got, exp);
    endtask

    // Target and scoreboard: works per transaction, not per FSM state
    logic             rand_mode = 1'b0;
    int               dir_waits = 0;
    logic [7:0]       dir_din = 8'h00;

    logic             rst_edge = 1'b1;
    logic [1:0]       req_edge, wr_edge, iom_edge;
    logic [1:0][19:0] addr_edge;
    logic [1:0][7:0]  wdata_edge;

    always @(posedge CLK) begin
        rst_edge   = RESET;
        req_edge   = req;
        wr_edge    = req_wr;
        iom_edge   = req_iom;
        addr_edge  = req_addr;
        wdata_edge = req_wdata;
    end

    bit         busy = 0, done_now, ptr = 0, m_id, m_wr, m_to;
    int         phase = 0, m_w = 0, ack_ph = 0;
    logic [7:0] m_din = 8'h00, m_wdata;
    logic [1:0] ack_last = 2'b00, elig, exp_ack;

    always @(negedge CLK) begin
        if (rst_edge) begin
            busy = 0; ptr = 0; ack_last = 2'b00; phase = 0;
        end else begin
            exp_ack  = 2'b00;
            done_now = 0;
            if (busy) begin
                phase++;
                chk("rd_strobe", RD, !(!m_wr && phase < ack_ph));
                chk("wr_strobe", WR, !(m_wr && phase < ack_ph));
                chk("den", DEN, m_wr);
                if (m_wr) chk("data_out", Data_out, m_wdata);
                if (phase == ack_ph) begin
                    exp_ack[m_id] = 1'b1;
                    chk("err", err, m_to);
                    if (!m_wr || m_to) chk("rdata", rdata, m_to ? 8'hFF : m_din);
                    busy = 0;
                    done_now = 1;
                end
            end
            chk("ack", ack, exp_ack);
            elig = req_edge & ~ack_last;
            if (ALE) begin
                chk("ale_while_busy", busy, 0);
                chk("ale_eligible", (elig != 2'b00), 1);
                m_id    = elig[ptr] ? ptr : !ptr;
                ptr     = !m_id;
                m_wr    = wr_edge[m_id];
                m_wdata = wdata_edge[m_id];
                chk("address", Address, addr_edge[m_id]);
                chk("iom", IOM, iom_edge[m_id]);
                busy   = 1;
                phase  = 0;
                m_w    = rand_mode ? int'($urandom_range(0, 10)) : dir_waits;
                m_din  = rand_mode ? 8'($urandom) : dir_din;
                m_to   = (m_w > MW);
                ack_ph = 3 + (m_to ? MW : m_w);
            end else if (!busy && !done_now) begin
                chk("grant_missing", elig, 2'b00);
            end
            ack_last = ack;
        end
        READY   = busy && (phase >= 2) && ((phase - 2) >= m_w);
        Data_in = m_din;
    end

    typedef struct {
        logic       id;
        logic       wr;
        logic       iom;
        logic [19:0] addr;
        logic [7:0] wdata;
        logic [7:0] din;
        int         waits;
        int         lat;
        logic       err;
        logic [7:0] rdata;
        int         strobes;
    } vec_t;

    vec_t tbl[6];

    task automatic do_xfer(input vec_t v);
        int n, strb;
        bit seen;
        logic [1:0] oh;
        oh = 2'b01 << v.id;
        dir_waits = v.waits;
        dir_din   = v.din;
        req_wr[v.id]    = v.wr;
        req_iom[v.id]   = v.iom;
        req_addr[v.id]  = v.addr;
        req_wdata[v.id] = v.wdata;
        req[v.id]       = 1'b1;
        n = 0; strb = 0; seen = 0;
        while (!seen && n < 40) begin
            @(negedge CLK);
            n++;
            if (!RD || !WR) strb++;
            if (ack != 2'b00) begin
                seen = 1;
                chk("tbl_ack", ack, oh);
                chk("tbl_latency", n, v.lat);
                chk("tbl_err", err, v.err);
                if (!v.wr) chk("tbl_rdata", rdata, v.rdata);
                chk("tbl_strobe_cycles", strb, v.strobes);
            end
        end
        if (!seen) chk("tbl_ack_timeout", 0, 1);
        @(negedge CLK);
        req[v.id] = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    initial begin
        int n, acks, maxw;
        int waitc[2];
        bit acked[2];
        logic [1:0] drop;
        logic [1:0] b2b_ids[4];

        tbl[0] = '{1'b0, 1'b0, 1'b0, 20'h01234, 8'h00, 8'h5A, 0,  4,  1'b0, 8'h5A, 2};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 20'h00060, 8'hC3, 8'h00, 3,  7,  1'b0, 8'h00, 5};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 20'hA5A5A, 8'h00, 8'h33, 99, 12, 1'b1, 8'hFF, 10};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 20'h0FFFF, 8'h00, 8'h7E, 0,  4,  1'b0, 8'h7E, 2};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 20'hFFFFF, 8'h81, 8'h00, 8,  12, 1'b0, 8'h00, 10};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 20'h00001, 8'h00, 8'h00, 7,  11, 1'b0, 8'h00, 9};
        b2b_ids[0] = 2'b01; b2b_ids[1] = 2'b10; b2b_ids[2] = 2'b01; b2b_ids[3] = 2'b10;

        RESET = 1'b1; req = '0; req_wr = '0; req_iom = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge CLK);
        chk("rst_ale", ALE, 0);
        chk("rst_rd", RD, 1);
        chk("rst_wr", WR, 1);
        chk("rst_iom", IOM, 0);
        chk("rst_address", Address, 0);
        chk("rst_data_out", Data_out, 0);
        chk("rst_den", DEN, 0);
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_rdata", rdata, 0);
        RESET = 1'b0;

        // Both ports request on the cycle after reset release and keep requesting
        @(negedge CLK);
        dir_waits = 0;
        req_addr[0] = 20'h11111; req_wr[0] = 1'b0; req_iom[0] = 1'b0;
        req_addr[1] = 20'h22222; req_wr[1] = 1'b1; req_iom[1] = 1'b1; req_wdata[1] = 8'h44;
        req = 2'b11;
        @(negedge CLK);
        chk("first_t1_ale", ALE, 1);
        chk("first_t1_address", Address, 20'h11111);
        n = 1; acks = 0; drop = 2'b00;
        while (acks < 4 && n < 40) begin
            @(negedge CLK);
            n++;
            req  = req & ~drop;
            drop = 2'b00;
            if (ack != 2'b00) begin
                chk("b2b_grant", ack, b2b_ids[acks]);
                chk("b2b_ack_cycle", n, 4 * (acks + 1));
                acks++;
                if (acks >= 3) drop = ack;
            end
        end
        chk("b2b_ack_count", acks, 4);
        @(negedge CLK);
        req = req & ~drop;
        repeat (2) @(negedge CLK);
        chk("b2b_idle", ALE, 0);

        // Reset lands during a wait state of a write
        dir_waits = 99;
        req_addr[1] = 20'h33333; req_wr[1] = 1'b1; req_iom[1] = 1'b1; req_wdata[1] = 8'h5C;
        req = 2'b10;
        repeat (5) @(negedge CLK);
        chk("tw_wr_low", WR, 0);
        RESET = 1'b1;
        req = 2'b00;
        @(negedge CLK);
        chk("abort_wr", WR, 1);
        chk("abort_ale", ALE, 0);
        chk("abort_ack", ack, 0);
        chk("abort_den", DEN, 0);
        chk("abort_address", Address, 0);
        RESET = 1'b0;
        repeat (3) @(negedge CLK);

        for (int i = 0; i < 6; i++) do_xfer(tbl[i]);

        // Random traffic; the scoreboard checks every cycle
        rand_mode = 1'b1;
        maxw = 0;
        for (int i = 0; i < 2; i++) begin waitc[i] = 0; acked[i] = 0; end
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            for (int i = 0; i < 2; i++) begin
                if (acked[i]) begin
                    acked[i] = 0;
                    req[i] = $urandom_range(0, 1) != 0;
                    req_wr[i] = 1'($urandom); req_iom[i] = 1'($urandom);
                    req_addr[i] = 20'($urandom); req_wdata[i] = 8'($urandom);
                end else if (req[i] && ack[i]) begin
                    acked[i] = 1;
                    waitc[i] = 0;
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req_wr[i] = 1'($urandom); req_iom[i] = 1'($urandom);
                    req_addr[i] = 20'($urandom); req_wdata[i] = 8'($urandom);
                    req[i] = 1'b1;
                end
                if (req[i] && !acked[i]) waitc[i]++;
                if (waitc[i] > maxw) maxw = waitc[i];
            end
        end
        req = 2'b00;
        repeat (30) @(negedge CLK);
        chk("no_starvation", (maxw <= 40), 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
